// File: rtl/core_pkg.sv
// Shared core constants and types.
//   NOP_INSN          : canonical bubble (addi zero, zero, 0)
//   DEFAULT_RESET_PC  : boot address used when a block does not override it
//   fetch_state_e     : instruction fetch FSM encoding
package core_pkg;

  localparam int          XLEN             = 32;
  localparam int          INSN_BITS        = 32;
  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding
// requests to instruction memory (req/gnt/rvalid) and buffers one fetched
// instruction for decode.
//   clock, reset                : rising-edge clock, async active-low reset
//   next_PC_select, target_PC   : redirect from decode, sampled on consume
//   stall                       : decode not ready, hold the buffer
//   imem_req/addr/gnt/rvalid/rdata : instruction memory handshake
//   PC, instruction, inst_valid : buffered instruction to decode
module fetch_unit
  import core_pkg::*;
#(
  parameter int                    ADDRESS_BITS = 16,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC   = ADDRESS_BITS'(DEFAULT_RESET_PC),
  parameter logic [31:0]           NOP          = NOP_INSN
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    next_PC_select,
  input  logic [ADDRESS_BITS-1:0] target_PC,
  input  logic                    stall,
  output logic                    imem_req,
  output logic [ADDRESS_BITS-1:0] imem_addr,
  input  logic                    imem_gnt,
  input  logic                    imem_rvalid,
  input  logic [31:0]             imem_rdata,
  output logic [ADDRESS_BITS-1:0] PC,
  output logic [31:0]             instruction,
  output logic                    inst_valid
);

  localparam logic [ADDRESS_BITS-1:0] RESET_FETCH = {RESET_PC[ADDRESS_BITS-1:2], 2'b00};

  fetch_state_e            state;
  logic [ADDRESS_BITS-1:0] fetch_pc;
  logic [ADDRESS_BITS-1:0] next_addr;
  logic                    consume;
  logic                    issue;

  // Redirect targets are aligned down; low bits are intentionally dropped.
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^target_PC[1:0];

  assign consume   = inst_valid & ~stall;
  // PC+4 wraps naturally at the address width.
  assign next_addr = next_PC_select ? {target_PC[ADDRESS_BITS-1:2], 2'b00}
                                    : PC + ADDRESS_BITS'(4);

  // The only combinational output path: the request for the following
  // instruction goes out in the same cycle decode takes the current one.
  assign issue     = (state == FULL) & consume;
  assign imem_req  = (state == REQ) | issue;
  assign imem_addr = issue ? next_addr : fetch_pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      fetch_pc    <= RESET_FETCH;
      PC          <= RESET_PC;
      instruction <= NOP;
      inst_valid  <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= REQ;
        REQ:  if (imem_gnt) state <= WAIT;
        WAIT: if (imem_rvalid) begin
          PC          <= fetch_pc;
          instruction <= imem_rdata;
          inst_valid  <= 1'b1;
          state       <= FULL;
        end
        FULL: if (consume) begin
          fetch_pc    <= next_addr;
          inst_valid  <= 1'b0;
          instruction <= NOP;
          state       <= imem_gnt ? WAIT : REQ;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import core_pkg::*;

  localparam int AW = 16;

  typedef struct {
    logic [AW-1:0] pc;
    logic [31:0]   insn;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          next_PC_select = 1'b0;
  logic [AW-1:0] target_PC = '0;
  logic          stall = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;
  logic [AW-1:0] PC;
  logic [31:0]   instruction;
  logic          inst_valid;

  // Memory model controls
  logic          gnt_en = 1'b1;
  logic          mem_auto = 1'b1;
  logic          mem_rv = 1'b0;
  logic [31:0]   mem_rd = '0;
  logic          spur = 1'b0;
  logic [31:0]   spur_data = '0;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  assign imem_gnt    = gnt_en & imem_req;
  assign imem_rvalid = (mem_rv & mem_auto) | spur;
  assign imem_rdata  = spur ? spur_data : mem_rd;

  fetch_unit #(.ADDRESS_BITS(AW), .RESET_PC(16'h0000), .NOP(32'h0000_0013)) dut (
    .clock(clock), .reset(reset),
    .next_PC_select(next_PC_select), .target_PC(target_PC), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PC(PC), .instruction(instruction), .inst_valid(inst_valid)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    if (a < 16'h0100) return 32'h0000_0013;
    if (a == 16'h0114) return 32'h0140_006f;
    return {16'hC0DE, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] pc, input logic [31:0] insn);
    exp_t e;
    e.pc = pc; e.insn = insn;
    sb.push_back(e);
  endtask

  // Memory: grant sampled late in the cycle, data returned one cycle later.
  initial begin
    logic          g;
    logic [AW-1:0] a;
    forever begin
      @(negedge clock); #3;
      g = imem_req & imem_gnt;
      a = imem_addr;
      @(posedge clock); #1;
      mem_rv = g;
      mem_rd = mem_word(a);
    end
  end

  // Monitor: every fresh buffered instruction is checked against the queue.
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clock);
      if (reset && inst_valid && !prev_v) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected: got PC %h with empty queue", PC);
        end else begin
          e = sb.pop_front();
          chk("sb_pc", 32'(PC), 32'(e.pc));
          chk("sb_insn", instruction, e.insn);
        end
      end
      prev_v = inst_valid;
    end
  end

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clock);
    while (!inst_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!inst_valid) chk("wait_valid_timeout", 32'(inst_valid), 32'd1);
  endtask

  // Called at a negedge with a stalled instruction buffered.
  task automatic consume(input logic sel, input logic [AW-1:0] tgt, input logic [AW-1:0] exp_addr);
    next_PC_select = sel;
    target_PC      = tgt;
    stall          = 1'b0;
    #1;
    chk("consume_req", 32'(imem_req), 32'd1);
    chk("consume_addr", 32'(imem_addr), 32'(exp_addr));
    @(posedge clock); #1;
    stall          = 1'b1;
    next_PC_select = 1'b0;
    target_PC      = 16'h0BAD;
  endtask

  initial begin
    int ngnt;
    int cyc;
    // ---- reset state ----
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_insn", instruction, 32'h0000_0013);
    chk("rst_pc", 32'(PC), 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'h0);

    // ---- free-running fetch, 1-cycle memory ----
    push(16'h0000, 32'h0000_0013);
    push(16'h0004, 32'h0000_0013);
    push(16'h0008, 32'h0000_0013);
    @(posedge clock); #1;
    reset = 1'b1;
    ngnt = 0;
    cyc  = 0;
    while (ngnt < 3 && cyc < 20) begin
      @(negedge clock);
      chk("pulse_valid", 32'(inst_valid), 32'((cyc >= 3) && (cyc % 2 == 1)));
      if (imem_req && imem_gnt) begin
        chk("seq_addr", 32'(imem_addr), 32'(4 * ngnt));
        ngnt++;
      end
      cyc++;
    end
    if (ngnt < 3) chk("seq_grants", 32'(ngnt), 32'd3);
    @(posedge clock); #1;
    stall = 1'b1;
    wait_valid();

    // ---- stall hold at PC 0x0008, spurious rvalid mid-stall ----
    for (int i = 0; i < 3; i++) begin
      chk("stall_pc", 32'(PC), 32'h0008);
      chk("stall_insn", instruction, 32'h0000_0013);
      chk("stall_req", 32'(imem_req), 32'd0);
      @(posedge clock); #1;
      spur      = (i == 1);
      spur_data = 32'hDEAD_BEEF;
      @(negedge clock);
    end
    spur = 1'b0;
    chk("spur_pc", 32'(PC), 32'h0008);
    chk("spur_insn", instruction, 32'h0000_0013);
    chk("spur_valid", 32'(inst_valid), 32'd1);
    chk("spur_req", 32'(imem_req), 32'd0);

    // ---- sequential then redirects ----
    push(16'h000C, 32'h0000_0013);
    consume(1'b0, 16'h0200, 16'h000C);
    wait_valid();
    push(16'h0114, 32'h0140_006f);
    consume(1'b1, 16'h0114, 16'h0114);
    wait_valid();
    push(16'h0128, 32'hC0DE_0128);
    consume(1'b1, 16'h0128, 16'h0128);
    wait_valid();
    push(16'h0154, 32'hC0DE_0154);
    consume(1'b1, 16'h0156, 16'h0154);
    wait_valid();
    push(16'hFFFC, 32'hC0DE_FFFC);
    consume(1'b1, 16'hFFFC, 16'hFFFC);
    wait_valid();

    // ---- wrap with delayed grant ----
    gnt_en = 1'b0;
    push(16'h0000, 32'h0000_0013);
    consume(1'b0, 16'h0040, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("gdly_req", 32'(imem_req), 32'd1);
      chk("gdly_addr", 32'(imem_addr), 32'h0000);
      chk("gdly_valid", 32'(inst_valid), 32'd0);
    end
    gnt_en = 1'b1;
    wait_valid();

    // ---- reset asserted while waiting for data ----
    mem_auto = 1'b0;
    consume(1'b0, 16'h0000, 16'h0004);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rw_valid", 32'(inst_valid), 32'd0);
    chk("rw_insn", instruction, 32'h0000_0013);
    chk("rw_req", 32'(imem_req), 32'd0);
    push(16'h0000, 32'h0000_0013);
    @(posedge clock); #1;
    reset     = 1'b1;
    spur      = 1'b1;
    spur_data = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("boot_valid", 32'(inst_valid), 32'd0);
    chk("boot_insn", instruction, 32'h0000_0013);
    chk("boot_req", 32'(imem_req), 32'd0);
    chk("boot_addr", 32'(imem_addr), 32'h0000);
    @(posedge clock); #1;
    spur     = 1'b0;
    mem_auto = 1'b1;
    stall    = 1'b0;
    @(negedge clock);
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", 32'(imem_addr), 32'h0000);
    chk("post_rst_valid", 32'(inst_valid), 32'd0);
    stall = 1'b1;
    wait_valid();
    @(negedge clock);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage for the RISC-V core. It is the supplier end of the fetch/decode interface.
- Owns the fetch PC and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake.
- Holds one fetched instruction in an output buffer and presents PC and instruction to decode.
- Consumes decode's next_PC_select/target_PC to redirect fetch. Replaces the combinational PC/instruction source used in stage-level benches.

Parameters:
- ADDRESS_BITS, 16, width of PC and instruction-memory address.
- RESET_PC, 0, first fetch address after reset.
- NOP, 32'h00000013, instruction value driven while no valid instruction is buffered (addi zero, zero, 0).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- next_PC_select  in  1  from decode; 1 = take target_PC instead of PC+4.
- target_PC  in  ADDRESS_BITS  from decode; redirect address.
- stall  in  1  downstream not ready; buffered instruction must be held.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDRESS_BITS  fetch address; word-aligned.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- PC  out  ADDRESS_BITS  address of the buffered instruction, to decode.
- instruction  out  32  buffered instruction, to decode.
- inst_valid  out  1  PC/instruction hold a valid fetched instruction.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=BOOT, fetch_pc=RESET_PC with bits[1:0] forced to 0.
  - PC=RESET_PC, instruction=NOP, inst_valid=0, imem_req=0, imem_addr=fetch_pc.
- consume = inst_valid & ~stall.
- next_addr = next_PC_select ? {target_PC[ADDRESS_BITS-1:2],2'b00} : PC+4.
  - PC+4 wraps modulo 2^ADDRESS_BITS, so 0xFFFC -> 0x0000.
  - Unaligned targets are silently aligned down.
- FSM states: BOOT, REQ, WAIT, FULL.
  - BOOT: imem_req=0. Next cycle -> REQ. imem_rvalid is ignored.
  - REQ: imem_req=1, imem_addr=fetch_pc.
    - imem_gnt=1 -> WAIT.
    - Otherwise stay in REQ; imem_req and imem_addr hold stable until granted.
  - WAIT: imem_req=0. On imem_rvalid:
    - PC<=fetch_pc, instruction<=imem_rdata, inst_valid<=1, -> FULL.
    - Minimum latency: grant cycle + 1 cycle to rvalid; inst_valid rises the cycle after rvalid.
  - FULL: inst_valid=1; PC and instruction held stable while stall=1, and imem_req=0.
    - On consume: fetch_pc<=next_addr, inst_valid<=0, instruction<=NOP.
    - On consume, imem_req=1 combinationally with imem_addr=next_addr (overlapped request).
    - Overlapped request granted the same cycle -> WAIT; otherwise -> REQ.
- Single outstanding request; at most one instruction buffered.
- Throughput with 1-cycle memory and no stall: one instruction per 2 cycles.
- imem_rvalid outside WAIT is ignored: no state change, no buffer write.
- next_PC_select/target_PC are sampled only on a consume cycle. Ignored while inst_valid=0 or stall=1.
- Redirect never cancels an in-flight fetch, because requests for the following instruction are issued only on consume.
- Reset asserted mid-WAIT: the returning rvalid arrives in BOOT and is dropped; fetch restarts at RESET_PC.
- All outputs are registered except imem_req/imem_addr in FULL on a consume cycle.

Decomposition:
- Shared package (core_pkg), added to existing core constants:
  - NOP encoding.
  - fetch state enum (BOOT=2'd0, REQ=2'd1, WAIT=2'd2, FULL=2'd3).
  - default RESET_PC.
- No sub-module: next-address logic is a few lines. A single module, roughly 150-200 lines.

Test Plan:
1. Reset: RESET_PC=0, memory grants immediately, rvalid 1 cycle after gnt, rdata=NOP, stall=0 -> imem_addr sequence 0x0000, 0x0004, 0x0008; inst_valid pulses every 2nd cycle with PC 0x0000, 0x0004, 0x0008.
2. Stall: while FULL with PC=0x0008, hold stall=1 for 3 cycles -> PC=0x0008 and instruction unchanged, imem_req=0; on stall release, imem_addr=0x000C the same cycle.
3. Redirect:
   - PC=0x0114, instruction=32'h0140006f, next_PC_select=1, target_PC=0x0128 -> imem_addr=0x0128 on the consume cycle; next buffered PC=0x0128.
   - target_PC=0x0156 -> fetch address 0x0154.
4. Wrap and grant delay:
   - Fetch at 0xFFFC, consume without redirect -> next imem_addr=0x0000.
   - imem_gnt held low 2 cycles -> imem_req=1 and imem_addr stable throughout.
5. Reset mid-operation: assert reset in WAIT, then deliver imem_rvalid=1 with rdata=32'hDEADBEEF during BOOT -> inst_valid stays 0, instruction=NOP, first post-reset fetch at RESET_PC.
6. Spurious rvalid: drive imem_rvalid=1 in FULL with stall=1 -> PC and instruction unchanged, no state change.
